// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: drives the combinational ROM, buffers returned
// words with their PCs in a small prefetch queue, and hands them to decode.
module inst_fetch_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int DEPTH = 2,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic          rom_ce,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_inst,
    input  logic          halt,
    input  logic          branch_flag,
    input  logic [AW-1:0] branch_target,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst_o,
    output logic [AW-1:0] pc_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] q_inst [DEPTH];
    logic [AW-1:0] q_pc [DEPTH];

    logic pop;
    logic can_push;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign can_push   = (count < CW'(DEPTH)) || pop;
    assign rom_ce     = !rst && !halt && !branch_flag && can_push;
    assign rom_addr   = fetch_pc;

    // Empty queue reads as zero so stale entries never leak to decode.
    assign inst_o = inst_valid ? q_inst[rd_ptr] : '0;
    assign pc_o   = inst_valid ? q_pc[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (branch_flag) begin
            // A same-cycle pop is still a handshake; the flush drops the rest.
            fetch_pc <= {branch_target[AW-1:2], 2'b00};
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (rom_ce) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + AW'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({rom_ce, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rom_ce) begin
            q_inst[wr_ptr] <= rom_inst;
            q_pc[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; ROM model returns word index (addr >> 2).
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        halt = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_o;
    logic [31:0] pc_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt20 = 0;

    always #5 clk = ~clk;

    assign rom_inst = {2'b00, rom_addr[31:2]};

    always @(posedge clk)
        if (inst_valid && inst_ready && pc_o == 32'h20) cnt20++;

    inst_fetch_ctrl dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr),
        .rom_inst(rom_inst), .halt(halt), .branch_flag(branch_flag),
        .branch_target(branch_target), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_o(inst_o), .pc_o(pc_o)
    );

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b1; halt = 1'b0; branch_flag = 1'b0; inst_ready = rdy;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b0 || rom_ce !== 1'b0 || pc_o !== 32'h0 ||
            inst_o !== 32'h0 || rom_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset: valid=%b ce=%b pc=%h inst=%h addr=%h, want 0s",
                     inst_valid, rom_ce, pc_o, inst_o, rom_addr);
        end
    endtask

    task automatic test_stream;
        do_reset(1'b1);
        #1;
        n_cmp++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h0 || inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_first: ce=%b addr=%h valid=%b, want 1 0 0",
                     rom_ce, rom_addr, inst_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (inst_valid !== 1'b1 || pc_o !== 32'(4 * i) || inst_o !== 32'(i) ||
                rom_addr !== 32'(4 * i + 4)) begin
                n_bad++;
                $display("FAIL stream[%0d]: valid=%b pc=%h inst=%h addr=%h, want pc=%h inst=%h",
                         i, inst_valid, pc_o, inst_o, rom_addr, 4 * i, i);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset(1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rom_ce !== 1'b0 || inst_valid !== 1'b1 || pc_o !== 32'h0 ||
                rom_addr !== 32'h8) begin
                n_bad++;
                $display("FAIL bp_full[%0d]: ce=%b valid=%b pc=%h addr=%h, want 0 1 0 8",
                         i, rom_ce, inst_valid, pc_o, rom_addr);
            end
        end
        inst_ready = 1'b1;
        #1;
        n_cmp++;
        if (rom_ce !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_full_pop: ce=%b, want 1", rom_ce);
        end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (inst_valid !== 1'b1 || pc_o !== 32'(4 * i) || inst_o !== 32'(i)) begin
                n_bad++;
                $display("FAIL bp_resume[%0d]: valid=%b pc=%h inst=%h, want pc=%h",
                         i, inst_valid, pc_o, inst_o, 4 * i);
            end
        end
    endtask

    task automatic test_branch_full;
        do_reset(1'b0);
        @(negedge clk);
        @(negedge clk);
        inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inst_ready = 1'b0;
        n_cmp++;
        if (pc_o !== 32'h8 || inst_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL brf_setup: pc=%h valid=%b, want 8 1", pc_o, inst_valid);
        end
        branch_flag = 1'b1; branch_target = 32'h103;
        #1;
        n_cmp++;
        if (rom_ce !== 1'b0) begin
            n_bad++;
            $display("FAIL brf_noissue: ce=%b, want 0", rom_ce);
        end
        @(negedge clk);
        branch_flag = 1'b0;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || rom_addr !== 32'h100 || rom_ce !== 1'b1) begin
            n_bad++;
            $display("FAIL brf_redirect: valid=%b addr=%h ce=%b, want 0 100 1",
                     inst_valid, rom_addr, rom_ce);
        end
        @(negedge clk);
        inst_ready = 1'b1;
        n_cmp++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h100 || inst_o !== 32'h40) begin
            n_bad++;
            $display("FAIL brf_target: valid=%b pc=%h inst=%h, want 1 100 40",
                     inst_valid, pc_o, inst_o);
        end
        @(negedge clk);
        n_cmp++;
        if (pc_o !== 32'h104 || inst_o !== 32'h41) begin
            n_bad++;
            $display("FAIL brf_next: pc=%h inst=%h, want 104 41", pc_o, inst_o);
        end
    endtask

    task automatic test_branch_pop;
        do_reset(1'b1);
        cnt20 = 0;
        repeat (9) @(negedge clk);
        n_cmp++;
        if (pc_o !== 32'h20 || inst_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL brp_head: pc=%h valid=%b, want 20 1", pc_o, inst_valid);
        end
        branch_flag = 1'b1; branch_target = 32'h200;
        @(negedge clk);
        branch_flag = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0 || rom_addr !== 32'h200) begin
            n_bad++;
            $display("FAIL brp_flush: valid=%b addr=%h, want 0 200", inst_valid, rom_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h200 || cnt20 != 1) begin
            n_bad++;
            $display("FAIL brp_next: valid=%b pc=%h pops20=%0d, want 1 200 1",
                     inst_valid, pc_o, cnt20);
        end
    endtask

    task automatic test_halt;
        do_reset(1'b0);
        @(negedge clk);
        @(negedge clk);
        halt = 1'b1; inst_ready = 1'b1;
        #1;
        n_cmp++;
        if (rom_ce !== 1'b0 || pc_o !== 32'h0) begin
            n_bad++;
            $display("FAIL halt_start: ce=%b pc=%h, want 0 0", rom_ce, pc_o);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h4 || rom_ce !== 1'b0 || rom_addr !== 32'h8) begin
            n_bad++;
            $display("FAIL halt_drain: valid=%b pc=%h ce=%b addr=%h, want 1 4 0 8",
                     inst_valid, pc_o, rom_ce, rom_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (inst_valid !== 1'b0 || rom_ce !== 1'b0 || rom_addr !== 32'h8) begin
                n_bad++;
                $display("FAIL halt_empty[%0d]: valid=%b ce=%b addr=%h, want 0 0 8",
                         i, inst_valid, rom_ce, rom_addr);
            end
        end
        halt = 1'b0;
        #1;
        n_cmp++;
        if (rom_ce !== 1'b1) begin
            n_bad++;
            $display("FAIL halt_release: ce=%b, want 1", rom_ce);
        end
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h8 || inst_o !== 32'h2) begin
            n_bad++;
            $display("FAIL halt_resume: valid=%b pc=%h inst=%h, want 1 8 2",
                     inst_valid, pc_o, inst_o);
        end
        halt = 1'b1; branch_flag = 1'b1; branch_target = 32'h42;
        @(negedge clk);
        branch_flag = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0 || rom_addr !== 32'h40 || rom_ce !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_branch: valid=%b addr=%h ce=%b, want 0 40 0",
                     inst_valid, rom_addr, rom_ce);
        end
        halt = 1'b0;
    endtask

    task automatic test_wrap_reset;
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        do_reset(1'b1);
        branch_flag = 1'b1; branch_target = 32'hFFFF_FFF8;
        @(negedge clk);
        branch_flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (inst_valid !== 1'b1 || pc_o !== exp_pc[i] ||
                inst_o !== {2'b00, exp_pc[i][31:2]}) begin
                n_bad++;
                $display("FAIL wrap[%0d]: valid=%b pc=%h inst=%h, want pc=%h",
                         i, inst_valid, pc_o, inst_o, exp_pc[i]);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (inst_valid !== 1'b0 || rom_ce !== 1'b0 || pc_o !== 32'h0 || rom_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL async_rst: valid=%b ce=%b pc=%h addr=%h, want 0 0 0 0",
                     inst_valid, rom_ce, pc_o, rom_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (inst_valid !== 1'b1 || pc_o !== 32'h0 || rom_addr !== 32'h4) begin
            n_bad++;
            $display("FAIL rst_restart: valid=%b pc=%h addr=%h, want 1 0 4",
                     inst_valid, pc_o, rom_addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_full();
        test_branch_pop();
        test_halt();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Sequences the combinational instruction ROM on behalf of the IF stage.
- Holds the fetch PC and drives ROM chip-enable and address.
- Captures each returned word, with its PC, into a small prefetch queue.
- Presents instructions to decode through a valid/ready handshake; handles branch redirects by flushing the queue and re-steering the PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded at reset.
- DEPTH, 2, prefetch queue entries; power of two, minimum 2.
- AW, 32, instruction address width (InstAddrBus).
- DW, 32, instruction word width (InstBus).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rom_ce  output  1  ROM chip enable; high when a fetch is issued this cycle.
- rom_addr  output  AW  ROM byte address; equals fetch_pc.
- rom_inst  input  DW  ROM read data, valid in the same cycle as rom_addr.
- halt  input  1  level; when high, no new fetches issue but the queue still drains.
- branch_flag  input  1  one-cycle redirect request.
- branch_target  input  AW  redirect byte address.
- inst_valid  output  1  queue head is valid.
- inst_ready  input  1  decode accepts the head this cycle.
- inst_o  output  DW  instruction at the queue head.
- pc_o  output  AW  PC of the instruction at the queue head.

Behaviour:
- Reset (asynchronous, any cycle, including mid-stream):
  - fetch_pc <= RESET_PC; queue emptied (read pointer, write pointer and count = 0).
  - inst_valid = 0, inst_o = 0, pc_o = 0; rom_ce = 0 while rst is high.
- Queue signals:
  - count ranges 0..DEPTH.
  - pop = inst_valid && inst_ready.
  - can_push = (count < DEPTH) || pop.
- Fetch issue (combinational):
  - rom_ce = !rst && !halt && !branch_flag && can_push.
  - rom_addr = fetch_pc at all times; it is ignored by the ROM when rom_ce = 0.
- Push: when rom_ce = 1, at the clock edge {rom_inst, fetch_pc} is written to the queue tail and fetch_pc <= fetch_pc + 4.
  - The addition wraps modulo 2^AW (32'hFFFF_FFFC + 4 -> 0).
- Output:
  - inst_valid = (count != 0).
  - inst_o / pc_o are driven from the head entry; both read as 0 when the queue is empty.
  - The head is stable while inst_valid && !inst_ready.
- Latency:
  - An issued fetch is visible at the queue head 1 cycle after issue.
  - Back-to-back throughput is 1 instruction/cycle when inst_ready is held high.
- Full queue: with count = DEPTH and no pop, rom_ce = 0 and fetch_pc holds.
  - Full + pop in the same cycle: push and pop both occur and count is unchanged.
- Branch (branch_flag = 1 in cycle t):
  - No fetch is issued in t.
  - At the edge, the queue is flushed (count = 0) and fetch_pc <= {branch_target[AW-1:2], 2'b00}; low address bits are forced to zero.
  - A pop in t is still a valid handshake: decode consumes the head, then the flush discards the rest.
  - The first fetch from the target issues in t+1; inst_valid is first high in t+2.
  - Branch overrides halt and any simultaneous push.
- Halt: fetch_pc is frozen; queued entries still pop normally.
  - A branch arriving during halt still updates fetch_pc and flushes the queue.
- Empty + inst_ready: no effect.

Test Plan:
- Reset release, RESET_PC = 0, inst_ready = 1, ROM word[i] = i → rom_addr sequence 0, 4, 8, ...; inst_valid rises one cycle after reset release; pc_o/inst_o = (0,0), (4,1), (8,2) on consecutive cycles.
- Backpressure: inst_ready = 0 for 5 cycles → count saturates at 2, rom_ce = 0 after 2 fetches, head holds pc 0; on inst_ready = 1, stream resumes with no gaps or duplicates.
- Branch while full: queue holds pcs 0x8 and 0xC; assert branch_flag with target 0x103 → next cycle rom_addr = 0x100 and rom_ce = 1; the following cycle pc_o = 0x100; pcs 0x8/0xC are never delivered after the flush.
- Branch + pop in the same cycle: head pc 0x20 accepted while branch_flag = 1 → 0x20 counted consumed exactly once; next delivered pc = target.
- Halt: halt = 1 for 4 cycles with inst_ready = 1 → queue drains, then inst_valid = 0 and fetch_pc frozen; deassert halt → fetch resumes from the frozen PC.
- Wrap and async reset: start at 32'hFFFF_FFF8 → delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000; assert rst mid-stream between edges → inst_valid and rom_ce drop immediately, and the PC restarts at RESET_PC.
